// File: rtl/tape_pkg.sv
// Shared types for the tape unit: operation codes, FSM states and opcode decoding.
package tape_pkg;

  typedef enum logic [2:0] {
    OP_PTR_INC   = 3'd0,
    OP_PTR_DEC   = 3'd1,
    OP_CELL_INC  = 3'd2,
    OP_CELL_DEC  = 3'd3,
    OP_CELL_LOAD = 3'd4,
    OP_CELL_READ = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Codes 6 and 7 are not defined and behave as a plain cell read.
  function automatic op_t decode_op(input logic [2:0] raw);
    case (raw)
      3'd0:    return OP_PTR_INC;
      3'd1:    return OP_PTR_DEC;
      3'd2:    return OP_CELL_INC;
      3'd3:    return OP_CELL_DEC;
      3'd4:    return OP_CELL_LOAD;
      default: return OP_CELL_READ;
    endcase
  endfunction

endpackage

// File: rtl/tape_unit.sv
// Tape (data pointer + cell) execution unit: one operation at a time against an
// external RAM with combinational read, single-cycle write.
module tape_unit
  import tape_pkg::*;
#(
  parameter int addr_bits = 16,
  parameter int data_bits = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [data_bits-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [data_bits-1:0] resp_data,
  output logic                 resp_zero,
  output logic [addr_bits-1:0] ptr,
  output logic [addr_bits-1:0] ram_address,
  output logic                 ram_write_enable,
  output logic [data_bits-1:0] ram_data_in,
  input  logic [data_bits-1:0] ram_data_out
);

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  op_t                  req_op_dec;
  logic [addr_bits-1:0] ptr_q, ptr_d;
  logic [data_bits-1:0] cell_q, cell_d;
  logic [data_bits-1:0] wdata_q, wdata_d;

  function automatic logic [data_bits-1:0] cell_step(input op_t op,
                                                     input logic [data_bits-1:0] v);
    if (op == OP_CELL_DEC) return v - 1'b1;
    return v + 1'b1;
  endfunction

  assign req_op_dec = decode_op(req_op);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    cell_d  = cell_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = req_op_dec;
          case (req_op_dec)
            OP_PTR_INC: begin
              ptr_d   = ptr_q + 1'b1;
              state_d = READ;
            end
            OP_PTR_DEC: begin
              ptr_d   = ptr_q - 1'b1;
              state_d = READ;
            end
            OP_CELL_LOAD: begin
              wdata_d = req_data;
              state_d = WRITE;
            end
            default: state_d = READ;
          endcase
        end
      end
      READ: begin
        cell_d = ram_data_out;
        if (op_q == OP_CELL_INC || op_q == OP_CELL_DEC) begin
          wdata_d = cell_step(op_q, ram_data_out);
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE: begin
        // The response reports the value just written.
        cell_d  = wdata_q;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_CELL_READ;
      ptr_q   <= '0;
      cell_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      cell_q  <= cell_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign ram_write_enable = (state_q == WRITE);
  assign ram_address      = ptr_q;
  assign ptr              = ptr_q;
  assign ram_data_in      = wdata_q;
  assign resp_data        = cell_q;
  assign resp_zero        = (cell_q == '0);

endmodule

// File: tb/tb_tape_unit.sv
// Bench for tape_unit: bench-side RAM, behavioural tape model, directed corner
// cases followed by randomized operation sequences.
module tb_tape_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic        resp_zero;
  logic [15:0] ptr;
  logic [15:0] ram_address;
  logic        ram_write_enable;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;

  tape_unit #(.addr_bits(16), .data_bits(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_data         (req_data),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_zero        (resp_zero),
    .ptr              (ptr),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  logic [7:0] mem [0:65535] = '{default: 8'h00};
  assign ram_data_out = mem[ram_address];
  always @(posedge clk) if (ram_write_enable) mem[ram_address] <= ram_data_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic        run_cmp = 1'b0;
  logic [15:0] exp_ptr = 16'h0000;
  logic [7:0]  mm [logic [15:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mread(input logic [15:0] a);
    if (mm.exists(a)) return mm[a];
    return 8'h00;
  endfunction

  // Behavioural tape: apply one operation, report result, latency and write count.
  task automatic model_apply(input logic [2:0] op, input logic [7:0] d,
                             output logic [7:0] res, output int lat, output int wr);
    lat = 2;
    wr  = 0;
    case (op)
      3'd0: begin exp_ptr = exp_ptr + 16'd1; res = mread(exp_ptr); end
      3'd1: begin exp_ptr = exp_ptr - 16'd1; res = mread(exp_ptr); end
      3'd2: begin res = mread(exp_ptr) + 8'd1; mm[exp_ptr] = res; lat = 3; wr = 1; end
      3'd3: begin res = mread(exp_ptr) - 8'd1; mm[exp_ptr] = res; lat = 3; wr = 1; end
      3'd4: begin res = d; mm[exp_ptr] = d; wr = 1; end
      default: res = mread(exp_ptr);
    endcase
  endtask

  // Pointer and RAM address must follow the model every cycle.
  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("ptr_track", ptr, exp_ptr);
      chk("addr_track", ram_address, exp_ptr);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] d, input int hold,
                        output logic [7:0] rdata, output logic rzero,
                        output int lat_o, output int wr_o);
    int n;
    int wr;
    int exp_lat;
    int exp_wr;
    logic [7:0] exp_d;
    rdata = 8'h00; rzero = 1'b0; lat_o = 0; wr_o = 0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_op     = op;
    req_data   = d;
    resp_ready = 1'b0;
    @(posedge clk);
    model_apply(op, d, exp_d, exp_lat, exp_wr);
    #1 req_valid = 1'b0;
    n = 0; wr = 0;
    do begin
      @(negedge clk);
      n++;
      if (ram_write_enable) wr++;
    end while (!resp_valid && n < 10);
    chk("latency", n, exp_lat);
    chk("we_cycles", wr, exp_wr);
    chk("resp_data", resp_data, exp_d);
    chk("resp_zero", resp_zero, exp_d == 8'h00);
    rdata = resp_data; rzero = resp_zero; lat_o = n; wr_o = wr;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, exp_d);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_we", ram_write_enable, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("post_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [7:0] r;
    logic       z;
    int         lat;
    int         wr;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_wdata", ram_data_in, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    run_cmp = 1'b1;

    run_op(3'd2, 8'h00, 0, r, z, lat, wr); chk("inc_1", r, 8'd1);
    run_op(3'd2, 8'h00, 0, r, z, lat, wr); chk("inc_2", r, 8'd2);
    run_op(3'd2, 8'h00, 0, r, z, lat, wr); chk("inc_3", r, 8'd3);
    chk("ram0_is_3", mem[0], 8'd3);

    run_op(3'd1, 8'h00, 0, r, z, lat, wr);
    chk("ptr_wrap", ptr, 16'hFFFF);
    run_op(3'd5, 8'h00, 0, r, z, lat, wr); chk("read_ffff", r, 8'h00);

    run_op(3'd4, 8'hFF, 0, r, z, lat, wr); chk("load_ff", r, 8'hFF);
    chk("load_lat", lat, 2);
    run_op(3'd2, 8'h00, 0, r, z, lat, wr); chk("inc_wrap", r, 8'h00);
    chk("inc_wrap_zero", z, 1);

    run_op(3'd3, 8'h00, 0, r, z, lat, wr); chk("dec_wrap", r, 8'hFF);
    chk("dec_lat", lat, 3);
    chk("dec_we", wr, 1);

    run_op(3'd7, 8'h00, 5, r, z, lat, wr); chk("undef_read", r, 8'hFF);

    // Abort a CELL_INC while it is reading; no write, no response.
    rst = 1'b1; #1; rst = 1'b0;
    exp_ptr = 16'h0000;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", resp_valid, 0);
    chk("abort_ptr", ptr, 0);
    chk("abort_we", ram_write_enable, 0);
    chk("abort_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("abort_ram0", mem[0], 8'd3);
    chk("abort_model", mem[0], mread(16'h0000));

    for (int i = 0; i < 300; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 2)),
             r, z, lat, wr);
    end

    run_cmp = 1'b0;
    foreach (mm[a]) chk("ram_final", mem[a], mm[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
